fetch_realigner: RTL

Instruction fetch realigner between the word-addressed instruction memory and the RV32IC core's decode stage. Converts the 32-bit word stream into one instruction per transfer, 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. Handles halfword-aligned redirects from branches and jumps, and holds under core stall. The existing decompressor sits downstream and consumes `instr_o`.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_realigner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch realigner.
//   fa_state_t    : realigner state (what the next instruction start looks like)
//   is_compressed : RVC test on a 16-bit parcel (low two bits not 2'b11)
//   HALF_W        : width of one instruction parcel
package fetch_pkg;

    localparam int HALF_W = 16;

    typedef enum logic [1:0] {
        ALIGNED   = 2'd0,  // next instruction starts at bit 0 of the fetched word
        UNALIGNED = 2'd1,  // next instruction starts at bit 16 of the fetched word
        BUFFERED  = 2'd2   // next instruction starts in the saved halfword
    } fa_state_t;

    function automatic logic is_compressed(input logic [HALF_W-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_realigner.sv
// Instruction fetch realigner: turns the 32-bit word stream from the
// instruction memory into one instruction per transfer (16-bit compressed or
// 32-bit, including 32-bit instructions straddling a word boundary).
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   imem_addr_o    word-aligned fetch address
//   imem_rdata_i   combinational read data for imem_addr_o
//   redirect_i     restart fetch at redirect_pc_i (bit 0 ignored)
//   redirect_pc_i  redirect target
//   stall_i        core cannot take the current instruction
//   instr_valid_o  instr_o / instr_pc_o hold a complete instruction
//   instr_o        instruction, compressed ones zero-extended
//   instr_pc_o     address of the instruction's first halfword
//   compressed_o   instruction is a 16-bit compressed one
module fetch_realigner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        compressed_o
);

    localparam fa_state_t RESET_STATE = RESET_PC[1] ? UNALIGNED : ALIGNED;

    fa_state_t          r_state;
    logic [31:0]        r_faddr;
    logic [31:0]        r_pc;
    logic [HALF_W-1:0]  r_hbuf;

    fa_state_t          w_state_nx;
    logic [31:0]        w_faddr_nx;
    logic [31:0]        w_pc_nx;
    logic [HALF_W-1:0]  w_hbuf_nx;
    logic               w_valid;
    logic [31:0]        w_instr;
    logic [HALF_W-1:0]  w_lo;
    logic [HALF_W-1:0]  w_hi;
    logic               w_unused_rpc0;

    assign w_lo          = imem_rdata_i[HALF_W-1:0];
    assign w_hi          = imem_rdata_i[31:HALF_W];
    assign w_unused_rpc0 = redirect_pc_i[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RESET_STATE;
            r_faddr <= {RESET_PC[31:2], 2'b00};
            r_pc    <= RESET_PC;
            r_hbuf  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_faddr <= w_faddr_nx;
            r_pc    <= w_pc_nx;
            r_hbuf  <= w_hbuf_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_faddr_nx = r_faddr;
        w_pc_nx    = r_pc;
        w_hbuf_nx  = r_hbuf;
        w_valid    = 1'b0;
        w_instr    = '0;

        if (redirect_i) begin
            // Redirect wins over stall; any buffered halfword is stale.
            w_faddr_nx = {redirect_pc_i[31:2], 2'b00};
            w_pc_nx    = {redirect_pc_i[31:1], 1'b0};
            w_hbuf_nx  = '0;
            w_state_nx = redirect_pc_i[1] ? UNALIGNED : ALIGNED;
        end else begin
            case (r_state)
                ALIGNED: begin
                    w_valid = 1'b1;
                    if (is_compressed(w_lo)) begin
                        w_instr = {16'h0, w_lo};
                        if (!stall_i) begin
                            w_hbuf_nx  = w_hi;
                            w_faddr_nx = r_faddr + 32'd4;
                            w_pc_nx    = r_pc + 32'd2;
                            w_state_nx = BUFFERED;
                        end
                    end else begin
                        w_instr = imem_rdata_i;
                        if (!stall_i) begin
                            w_faddr_nx = r_faddr + 32'd4;
                            w_pc_nx    = r_pc + 32'd4;
                        end
                    end
                end
                UNALIGNED: begin
                    if (is_compressed(w_hi)) begin
                        w_valid = 1'b1;
                        w_instr = {16'h0, w_hi};
                        if (!stall_i) begin
                            w_faddr_nx = r_faddr + 32'd4;
                            w_pc_nx    = r_pc + 32'd2;
                            w_state_nx = ALIGNED;
                        end
                    end else begin
                        // First half of a straddling instruction: nothing to
                        // present yet, so this bubble ignores stall.
                        w_hbuf_nx  = w_hi;
                        w_faddr_nx = r_faddr + 32'd4;
                        w_state_nx = BUFFERED;
                    end
                end
                BUFFERED: begin
                    w_valid = 1'b1;
                    if (is_compressed(r_hbuf)) begin
                        // The current word is still unconsumed, so faddr stays.
                        w_instr = {16'h0, r_hbuf};
                        if (!stall_i) begin
                            w_pc_nx    = r_pc + 32'd2;
                            w_state_nx = ALIGNED;
                        end
                    end else begin
                        w_instr = {w_lo, r_hbuf};
                        if (!stall_i) begin
                            w_hbuf_nx  = w_hi;
                            w_faddr_nx = r_faddr + 32'd4;
                            w_pc_nx    = r_pc + 32'd4;
                        end
                    end
                end
                default: begin
                    w_state_nx = ALIGNED;
                end
            endcase
        end
    end

    assign imem_addr_o   = r_faddr;
    assign instr_valid_o = w_valid & reset;
    assign instr_o       = w_instr;
    assign instr_pc_o    = r_pc;
    assign compressed_o  = is_compressed(w_instr[HALF_W-1:0]);

endmodule
